pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 159 +++++++++++++++
 tb/tb_pc_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALTED control, one-entry pending redirect, fetch counter.
// Define PC_GEN_ALIGN_CHK_EN to enable redirect-target alignment checking (misalign pulse + low-bit clear).
module pc_gen #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = 32'h0000_0000,
    parameter int              STEP      = 4,
    parameter logic [PC_W-1:0] EXC_VEC   = 32'h0000_0080,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             br_valid,
    input  logic [PC_W-1:0]  br_target,
    input  logic             exc_valid,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             misalign
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_nxt_s;
    logic [PC_W-1:0]   pend_tgt_r;
    logic [PC_W-1:0]   pend_tgt_nxt_s;
    logic [PC_W-1:0]   tgt_s;
    logic              pend_vld_r;
    logic              pend_vld_nxt_s;
    logic              fetch_vld_s;
    logic              halted_s;
    logic              fire_s;
    logic              upd_s;
    logic [CNT_W-1:0]  cnt_r;

`ifdef PC_GEN_ALIGN_CHK_EN
    localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);
    logic mis_s;
    logic misalign_r;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; halt_req dominates resume
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BOOT:    state_nxt_s = RUN;
            RUN:     state_nxt_s = halt_req ? HALTED : RUN;
            HALTED: begin
                if (halt_req) begin
                    state_nxt_s = HALTED;
                end else if (resume) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HALTED;
                end
            end
            default: state_nxt_s = BOOT;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        fetch_vld_s = (state_r == RUN) & ~stall;
        halted_s    = (state_r == HALTED);
    end

    // Next-PC selection and pending-redirect capture
    always_comb begin
        fire_s         = fetch_vld_s & fetch_ready;
        upd_s          = fire_s | (~fetch_vld_s & (exc_valid | br_valid | pend_vld_r));
        tgt_s          = br_valid ? br_target : pend_tgt_r;
        pc_nxt_s       = pc_r;
        pend_vld_nxt_s = pend_vld_r;
        pend_tgt_nxt_s = pend_tgt_r;
        if (upd_s) begin
            // Any update event supersedes whatever was pending
            pend_vld_nxt_s = 1'b0;
            if (exc_valid) begin
                pc_nxt_s = EXC_VEC;
            end else if (br_valid | pend_vld_r) begin
`ifdef PC_GEN_ALIGN_CHK_EN
                pc_nxt_s = tgt_s & ~ALIGN_MASK;
`else
                pc_nxt_s = tgt_s;
`endif
            end else begin
                pc_nxt_s = pc_r + PC_W'(STEP);
            end
        end else if (exc_valid | br_valid) begin
            pend_vld_nxt_s = 1'b1;
            pend_tgt_nxt_s = exc_valid ? EXC_VEC : br_target;
        end else begin
            pend_vld_nxt_s = pend_vld_r;
        end
    end

    // PC, pending register and fetch counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r       <= RESET_VEC;
            pend_vld_r <= 1'b0;
            pend_tgt_r <= '0;
            cnt_r      <= '0;
        end else begin
            pc_r       <= pc_nxt_s;
            pend_vld_r <= pend_vld_nxt_s;
            pend_tgt_r <= pend_tgt_nxt_s;
            if (fire_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

`ifdef PC_GEN_ALIGN_CHK_EN
    // Misaligned target detection on a target-loading update
    always_comb begin
        mis_s = upd_s & ~exc_valid & (br_valid | pend_vld_r) & (|(tgt_s & ALIGN_MASK));
    end

    // Registered one-cycle misalign pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= mis_s;
        end
    end

    assign misalign = misalign_r;
`else
    assign misalign = 1'b0;
`endif

    assign fetch_valid = fetch_vld_s;
    assign halted      = halted_s;
    assign pc          = pc_r;
    assign fetch_cnt   = cnt_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: behavioural model checked every cycle plus directed literal checks.
module tb_pc_gen;
    localparam int          PC_W      = 32;
    localparam int          CNT_W     = 4;
    localparam int          STEP      = 4;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0080;

    logic             clk         = 1'b0;
    logic             resetn      = 1'b0;
    logic             stall       = 1'b0;
    logic             halt_req    = 1'b0;
    logic             resume      = 1'b0;
    logic             br_valid    = 1'b0;
    logic [PC_W-1:0]  br_target   = 32'h0;
    logic             exc_valid   = 1'b0;
    logic             fetch_ready = 1'b1;
    logic             fetch_valid;
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;
    logic             misalign;

    int errors = 0;
    int checks = 0;

    pc_gen #(
        .PC_W(PC_W), .RESET_VEC(RESET_VEC), .STEP(STEP), .EXC_VEC(EXC_VEC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .halt_req(halt_req), .resume(resume),
        .br_valid(br_valid), .br_target(br_target), .exc_valid(exc_valid),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc(pc), .halted(halted),
        .fetch_cnt(fetch_cnt), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: mode 0=boot, 1=run, 2=halted
    int          m_mode = 0;
    logic [31:0] m_pc   = RESET_VEC;
    int          m_cnt  = 0;
    logic        m_pv   = 1'b0;
    logic [31:0] m_pt   = 32'h0;
    logic        m_mis  = 1'b0;

    function automatic logic [31:0] fix_target(input logic [31:0] t, output logic mis);
        mis = 1'b0;
`ifdef PC_GEN_ALIGN_CHK_EN
        if (t % STEP != 0) begin
            mis = 1'b1;
            return t - (t % STEP);
        end
`endif
        return t;
    endfunction

    // Model update and per-cycle compare
    initial begin
        logic fv;
        logic fire;
        logic mis;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_mode = 0; m_pc = RESET_VEC; m_cnt = 0; m_pv = 1'b0; m_mis = 1'b0;
            end else begin
                fv    = (m_mode == 1) && !stall;
                fire  = fv && fetch_ready;
                m_mis = 1'b0;
                if (fire || (!fv && (exc_valid || br_valid || m_pv))) begin
                    if (exc_valid)     m_pc = EXC_VEC;
                    else if (br_valid) begin m_pc = fix_target(br_target, mis); m_mis = mis; end
                    else if (m_pv)     begin m_pc = fix_target(m_pt, mis); m_mis = mis; end
                    else               m_pc = 32'((64'(m_pc) + 64'(STEP)) % 64'h1_0000_0000);
                    m_pv = 1'b0;
                end else if (exc_valid || br_valid) begin
                    m_pv = 1'b1;
                    m_pt = exc_valid ? EXC_VEC : br_target;
                end
                if (fire) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (m_mode == 0)                    m_mode = 1;
                else if (m_mode == 1 && halt_req)   m_mode = 2;
                else if (m_mode == 2 && !halt_req && resume) m_mode = 1;
            end
            #1;
            chk("model_pc", pc, m_pc);
            chk("model_cnt", 32'(fetch_cnt), 32'(m_cnt));
            chk("model_halted", 32'(halted), 32'(m_mode == 2));
            chk("model_fetch_valid", 32'(fetch_valid), 32'((m_mode == 1) && !stall && resetn));
            chk("model_misalign", 32'(misalign), 32'(m_mis));
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0); chk("rst_fv", 32'(fetch_valid), 32'h0);
        chk("rst_cnt", 32'(fetch_cnt), 32'h0); chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        resetn = 1'b1;
        @(negedge clk); chk("boot_pc", pc, 32'h0); chk("boot_fv", 32'(fetch_valid), 32'h1);
        chk("boot_cnt", 32'(fetch_cnt), 32'h0);
        @(negedge clk); chk("seq_pc4", pc, 32'h4); chk("seq_cnt1", 32'(fetch_cnt), 32'h1);
        @(negedge clk); chk("seq_pc8", pc, 32'h8); chk("seq_cnt2", 32'(fetch_cnt), 32'h2);
        fetch_ready = 1'b0; br_valid = 1'b1; br_target = 32'h100;
        @(negedge clk); chk("hold_pc_c1", pc, 32'h8); br_valid = 1'b0;
        @(negedge clk); chk("hold_pc_c2", pc, 32'h8);
        @(negedge clk); chk("hold_pc_c3", pc, 32'h8); fetch_ready = 1'b1;
        @(negedge clk); chk("pend_pc", pc, 32'h100); chk("pend_cnt", 32'(fetch_cnt), 32'h3);
        @(negedge clk); chk("pend_cleared_pc", pc, 32'h104);
        exc_valid = 1'b1; br_valid = 1'b1; br_target = 32'h200;
        @(negedge clk); chk("exc_prio_pc", pc, 32'h80); chk("exc_cnt", 32'(fetch_cnt), 32'h5);
        exc_valid = 1'b0; br_target = 32'h10;
        @(negedge clk); chk("br_pc10", pc, 32'h10);
        br_valid = 1'b0; halt_req = 1'b1; stall = 1'b1;
        @(negedge clk); chk("halt_halted", 32'(halted), 32'h1); chk("halt_fv", 32'(fetch_valid), 32'h0);
        chk("halt_pc", pc, 32'h10); halt_req = 1'b0; stall = 1'b0;
        @(negedge clk); chk("halt_frozen", pc, 32'h10); br_valid = 1'b1; br_target = 32'h40;
        @(negedge clk); chk("halt_br_pc", pc, 32'h40); chk("halt_br_halted", 32'(halted), 32'h1);
        br_valid = 1'b0; resume = 1'b1;
        @(negedge clk); chk("resume_halted", 32'(halted), 32'h0); chk("resume_pc", pc, 32'h40);
        resume = 1'b0;
        @(negedge clk); chk("resume_step", pc, 32'h44); chk("resume_cnt", 32'(fetch_cnt), 32'h7);
        fetch_ready = 1'b0; br_valid = 1'b1; br_target = 32'h500;
        @(negedge clk); br_valid = 1'b0; exc_valid = 1'b1;
        @(negedge clk); exc_valid = 1'b0; fetch_ready = 1'b1; chk("overwrite_hold", pc, 32'h44);
        @(negedge clk); chk("overwrite_pc", pc, 32'h80); chk("overwrite_cnt", 32'(fetch_cnt), 32'h8);
        fetch_ready = 1'b0; br_valid = 1'b1; br_target = 32'h300;
        @(negedge clk); br_valid = 1'b0; stall = 1'b1; chk("pre_rst_pc", pc, 32'h80);
        #2 resetn = 1'b0;
        #1 chk("async_rst_pc", pc, RESET_VEC); chk("async_rst_cnt", 32'(fetch_cnt), 32'h0);
        @(negedge clk); resetn = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
        @(negedge clk); chk("post_rst_pc", pc, RESET_VEC); chk("post_rst_fv", 32'(fetch_valid), 32'h1);
        repeat (17) @(negedge clk);
        chk("wrap_cnt", 32'(fetch_cnt), 32'h1); chk("wrap_pc", pc, 32'h44);
        br_valid = 1'b1; br_target = 32'h103;
        @(negedge clk); br_valid = 1'b0;
`ifdef PC_GEN_ALIGN_CHK_EN
        chk("align_pc", pc, 32'h100); chk("align_mis", 32'(misalign), 32'h1);
`else
        chk("align_pc", pc, 32'h103); chk("align_mis", 32'(misalign), 32'h0);
`endif
        @(negedge clk); chk("align_mis_drop", 32'(misalign), 32'h0); chk("align_cnt", 32'(fetch_cnt), 32'h3);
        stall = 1'b1; br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
        @(negedge clk); chk("stall_br_pc", pc, 32'hFFFF_FFFC); chk("stall_br_cnt", 32'(fetch_cnt), 32'h3);
        stall = 1'b0; br_valid = 1'b0;
        @(negedge clk); chk("pc_wrap", pc, 32'h0); chk("pc_wrap_cnt", 32'(fetch_cnt), 32'h4);
        halt_req = 1'b1;
        @(negedge clk); chk("halt_fire_pc", pc, 32'h4); chk("halt_fire_halted", 32'(halted), 32'h1);
        resume = 1'b1;
        @(negedge clk); chk("halt_over_resume", 32'(halted), 32'h1); halt_req = 1'b0;
        @(negedge clk); chk("resume_only", 32'(halted), 32'h0); resume = 1'b0;
        for (int i = 0; i < 120; i++) begin
            stall       = ($urandom % 4) == 0;
            fetch_ready = ($urandom % 3) != 0;
            br_valid    = ($urandom % 5) == 0;
            br_target   = $urandom;
            exc_valid   = ($urandom % 9) == 0;
            halt_req    = ($urandom % 12) == 0;
            resume      = ($urandom % 3) == 0;
            @(negedge clk);
        end
        stall = 1'b0; br_valid = 1'b0; exc_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
